// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// One registered stage between instruction decode and execute. Maps
// {op_code, funct3, funct7, alu_op} to an ALU control code for RV32I
// (plus optional RV32M), flags unsupported encodings, and keeps saturating
// counters of completed and illegal output handshakes.
module alu_decode_stage #(
    parameter int ALU_CTRL_W = 5,
    parameter int EN_MEXT    = 1,
    parameter int TAG_W      = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_op_code,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [1:0]            in_alu_op,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CTRL_W-1:0] out_alu_control,
    output logic                  out_illegal,
    output logic                  out_multicycle,
    output logic [TAG_W-1:0]      out_tag,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt_decoded,
    output logic [CNT_W-1:0]      cnt_illegal
);

    // ALU operation codes
    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_SLL    = 5'd4;
    localparam logic [4:0] OP_SLT    = 5'd5;
    localparam logic [4:0] OP_SLTU   = 5'd6;
    localparam logic [4:0] OP_XOR    = 5'd7;
    localparam logic [4:0] OP_SRL    = 5'd8;
    localparam logic [4:0] OP_SRA    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_PASS_B = 5'd18;

    // funct7 patterns of interest
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [4:0]            code_s;
    logic                  illegal_s;
    logic                  multi_s;
    logic [ALU_CTRL_W-1:0] dec_ctrl_s;
    logic                  dec_multi_s;
    logic                  accept_s;
    logic                  handshake_s;

    logic                  out_valid_r;
    logic [ALU_CTRL_W-1:0] out_alu_control_r;
    logic                  out_illegal_r;
    logic                  out_multicycle_r;
    logic [TAG_W-1:0]      out_tag_r;
    logic [CNT_W-1:0]      cnt_decoded_r;
    logic [CNT_W-1:0]      cnt_illegal_r;

    // Decode the incoming instruction fields into an operation code and flags
    always_comb begin
        code_s    = OP_ADD;
        illegal_s = 1'b0;
        multi_s   = 1'b0;
        case (in_alu_op)
            2'b00: code_s = OP_ADD;
            2'b01: begin
                case (in_funct3)
                    3'b000, 3'b001: code_s = OP_SUB;
                    3'b100, 3'b101: code_s = OP_SLT;
                    3'b110, 3'b111: code_s = OP_SLTU;
                    default:        illegal_s = 1'b1;
                endcase
            end
            2'b10: begin
                if (in_op_code[5]) begin
                    // R-type: funct7 selects base, alternate or M-extension group
                    case (in_funct7)
                        F7_BASE: begin
                            case (in_funct3)
                                3'b000:  code_s = OP_ADD;
                                3'b001:  code_s = OP_SLL;
                                3'b010:  code_s = OP_SLT;
                                3'b011:  code_s = OP_SLTU;
                                3'b100:  code_s = OP_XOR;
                                3'b101:  code_s = OP_SRL;
                                3'b110:  code_s = OP_OR;
                                3'b111:  code_s = OP_AND;
                                default: illegal_s = 1'b1;
                            endcase
                        end
                        F7_ALT: begin
                            case (in_funct3)
                                3'b000:  code_s = OP_SUB;
                                3'b101:  code_s = OP_SRA;
                                default: illegal_s = 1'b1;
                            endcase
                        end
                        F7_MEXT: begin
                            if (EN_MEXT != 0) begin
                                code_s  = OP_MUL + {2'b00, in_funct3};
                                multi_s = 1'b1;
                            end else begin
                                illegal_s = 1'b1;
                            end
                        end
                        default: illegal_s = 1'b1;
                    endcase
                end else begin
                    // I-type: funct7 only matters for the shift-immediate forms
                    case (in_funct3)
                        3'b000: code_s = OP_ADD;
                        3'b001: begin
                            if (in_funct7 == F7_BASE) begin
                                code_s = OP_SLL;
                            end else begin
                                illegal_s = 1'b1;
                            end
                        end
                        3'b010: code_s = OP_SLT;
                        3'b011: code_s = OP_SLTU;
                        3'b100: code_s = OP_XOR;
                        3'b101: begin
                            if (in_funct7 == F7_BASE) begin
                                code_s = OP_SRL;
                            end else if (in_funct7 == F7_ALT) begin
                                code_s = OP_SRA;
                            end else begin
                                illegal_s = 1'b1;
                            end
                        end
                        3'b110:  code_s = OP_OR;
                        3'b111:  code_s = OP_AND;
                        default: illegal_s = 1'b1;
                    endcase
                end
            end
            2'b11:   code_s = OP_PASS_B;
            default: illegal_s = 1'b1;
        endcase
    end

    // Illegal encodings still flow but carry a neutral control code
    assign dec_ctrl_s  = illegal_s ? {ALU_CTRL_W{1'b0}} : ALU_CTRL_W'(code_s);
    assign dec_multi_s = multi_s & ~illegal_s;

    assign in_ready    = ~out_valid_r | out_ready;
    assign accept_s    = in_valid & in_ready;
    assign handshake_s = out_valid_r & out_ready & ~flush;

    // Single pipeline register; flush wins, then a new accept, then a drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r       <= 1'b0;
            out_alu_control_r <= {ALU_CTRL_W{1'b0}};
            out_illegal_r     <= 1'b0;
            out_multicycle_r  <= 1'b0;
            out_tag_r         <= {TAG_W{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r       <= 1'b1;
            out_alu_control_r <= dec_ctrl_s;
            out_illegal_r     <= illegal_s;
            out_multicycle_r  <= dec_multi_s;
            out_tag_r         <= in_tag;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Saturating statistics counters; clear has priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_decoded_r <= {CNT_W{1'b0}};
            cnt_illegal_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_decoded_r <= {CNT_W{1'b0}};
            cnt_illegal_r <= {CNT_W{1'b0}};
        end else begin
            if (handshake_s && (cnt_decoded_r != CNT_MAX)) begin
                cnt_decoded_r <= cnt_decoded_r + CNT_ONE;
            end
            if (handshake_s && out_illegal_r && (cnt_illegal_r != CNT_MAX)) begin
                cnt_illegal_r <= cnt_illegal_r + CNT_ONE;
            end
        end
    end

    assign out_valid       = out_valid_r;
    assign out_alu_control = out_alu_control_r;
    assign out_illegal     = out_illegal_r;
    assign out_multicycle  = out_multicycle_r;
    assign out_tag         = out_tag_r;
    assign cnt_decoded     = cnt_decoded_r;
    assign cnt_illegal     = cnt_illegal_r;

endmodule
